rs232_tx_fifo: RTL and testbench

//  Byte FIFO and handshake driver directly upstream of the RS-232 transmitter.

---
 rtl/rs232_tx_fifo_pkg.sv | 9 +
 rtl/rs232_tx_fifo_if.sv | 32 +++
 rtl/rs232_fifo_mem.sv | 18 +
 rtl/rs232_tx_fifo.sv | 85 ++++++++
 tb/tb_rs232_tx_fifo.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/rs232_tx_fifo_pkg.sv
// rs232_pkg: drain-FSM state encodings and byte width shared by the RS-232 TX FIFO files
package rs232_pkg;
  localparam int RS232_BYTE_W = 8;
  typedef enum logic [1:0] {
    RS232_TXF_IDLE = 2'd0,
    RS232_TXF_REQ  = 2'd1,
    RS232_TXF_WAIT = 2'd2
  } rs232_txf_state_e;
endpackage

// File: rtl/rs232_tx_fifo_if.sv
// rs232_tx_fifo_if: host write port plus transmitter handshake of rs232_tx_fifo
// WrData/Write come from host logic, Full/Empty report occupancy back to it.
// TxData/Send go to the transmitter, Busy is its busy/acknowledge.
// With RS232_TX_FIFO_STATUS_EN defined, Level (occupancy) and sticky Overflow are added.
// slave = the FIFO, master = the surrounding host/transmitter side.
interface rs232_tx_fifo_if import rs232_pkg::*; #(parameter int AddrBits = 4);
  logic [RS232_BYTE_W-1:0] WrData;
  logic Write;
  logic Full;
  logic Empty;
  logic [RS232_BYTE_W-1:0] TxData;
  logic Send;
  logic Busy;
`ifdef RS232_TX_FIFO_STATUS_EN
  logic [AddrBits:0] Level;
  logic Overflow;
`endif
  modport slave (
    input WrData, Write, Busy,
    output Full, Empty, TxData, Send
`ifdef RS232_TX_FIFO_STATUS_EN
    , Level, Overflow
`endif
  );
  modport master (
    output WrData, Write, Busy,
    input Full, Empty, TxData, Send
`ifdef RS232_TX_FIFO_STATUS_EN
    , Level, Overflow
`endif
  );
endinterface

// File: rtl/rs232_fifo_mem.sv
// rs232_fifo_mem: 2**AddrBits x Width array, synchronous write, combinational read
// clk clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o asynchronous read port.
module rs232_fifo_mem #(
  parameter int AddrBits = 4,
  parameter int Width = 8
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [Width-1:0]    rdata_o
);
  logic [Width-1:0] mem_q [2**AddrBits];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: byte FIFO feeding an RS-232 transmitter through its TxData/Send/Busy handshake
// Clk clock, Reset asynchronous active-high; bus (slave modport) carries WrData/Write/Full/Empty
// on the host side and TxData/Send/Busy on the transmitter side.
// Optional RS232_TX_FIFO_STATUS_EN adds Level and sticky Overflow outputs on bus.
module rs232_tx_fifo import rs232_pkg::*; #(
  parameter int AddrBits = 4
) (
  input logic           Clk,
  input logic           Reset,
  rs232_tx_fifo_if.slave bus
);
  localparam logic [AddrBits:0] FULL_CNT = {1'b1, {AddrBits{1'b0}}};
  rs232_txf_state_e st_q, st_d;
  logic [AddrBits-1:0] wr_q, rd_q;
  logic [AddrBits:0] cnt_q, cnt_d;
  logic full_q, empty_q, send_q, send_d;
  logic [RS232_BYTE_W-1:0] tx_q, tx_d, rd_data;
  logic push, pop;
  // A write while Full is dropped outright, regardless of a same-cycle pop.
  assign push = bus.Write && !full_q;
  assign pop = (st_q == RS232_TXF_IDLE) && !bus.Busy && !empty_q;
  assign cnt_d = cnt_q + {{AddrBits{1'b0}}, push} - {{AddrBits{1'b0}}, pop};
  rs232_fifo_mem #(.AddrBits(AddrBits), .Width(RS232_BYTE_W)) u_mem (
    .clk(Clk),
    .we_i(push),
    .waddr_i(wr_q),
    .wdata_i(bus.WrData),
    .raddr_i(rd_q),
    .rdata_o(rd_data)
  );
  // WAIT holds off the next request until the transmitter has finished the frame and dropped Busy.
  always_comb begin
    st_d = st_q;
    send_d = send_q;
    tx_d = tx_q;
    case (st_q)
      RS232_TXF_IDLE: if (pop) begin
        tx_d = rd_data;
        send_d = 1'b1;
        st_d = RS232_TXF_REQ;
      end
      RS232_TXF_REQ: if (bus.Busy) begin
        send_d = 1'b0;
        st_d = RS232_TXF_WAIT;
      end
      RS232_TXF_WAIT: st_d = bus.Busy ? RS232_TXF_WAIT : RS232_TXF_IDLE;
      default: begin
        send_d = 1'b0;
        st_d = RS232_TXF_IDLE;
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      st_q <= RS232_TXF_IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      send_q <= 1'b0;
      tx_q <= '0;
    end else begin
      st_q <= st_d;
      wr_q <= wr_q + {{(AddrBits-1){1'b0}}, push};
      rd_q <= rd_q + {{(AddrBits-1){1'b0}}, pop};
      cnt_q <= cnt_d;
      full_q <= cnt_d == FULL_CNT;
      empty_q <= cnt_d == '0;
      send_q <= send_d;
      tx_q <= tx_d;
    end
  assign bus.Full = full_q;
  assign bus.Empty = empty_q;
  assign bus.TxData = tx_q;
  assign bus.Send = send_q;
`ifdef RS232_TX_FIFO_STATUS_EN
  logic ovf_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) ovf_q <= 1'b0;
    else ovf_q <= ovf_q | (bus.Write & full_q);
  assign bus.Level = cnt_q;
  assign bus.Overflow = ovf_q;
`endif
endmodule

// File: tb/tb_rs232_tx_fifo.sv
// tb_rs232_tx_fifo: rs232_tx_fifo driven against a 13-clock-per-bit transmitter model and serial decoder
module tb_rs232_tx_fifo;
  import rs232_pkg::*;
  localparam int BIT = 13;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b1;
  logic stall = 1'b0;
  logic line = 1'b1;
  logic seen;
  logic send_prev;
  logic [7:0] rxb;
  logic [9:0] sh;
  int tst, boot, bc, nb;
  int total = 0, bad = 0, ferr = 0, pulses = 0;
  logic [7:0] rxq[$];
  always #5 clk = ~clk;
  rs232_tx_fifo_if #(.AddrBits(4)) bus();
  rs232_tx_fifo #(.AddrBits(4)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rx_at(input int k);
    return (k < rxq.size()) ? {24'h0, rxq[k]} : 32'hxxxxxxxx;
  endfunction
  task automatic wait_rx(input int n, input int lim);
    int k = 0;
    while (rxq.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", rxq.size(), n);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (bus.Busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("tx_idle", bus.Busy, 0);
  endtask
  // transmitter model: busy out of reset, frame = start, 8 data LSB first, stop; Busy drops once Send is low
  initial begin : txm
    tst = 0; boot = 4; bc = 0; nb = 0; sh = '0;
    bus.Busy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tst = 0; boot = 4; bus.Busy = 1'b1; line = 1'b1;
      end else case (tst)
        0: if (boot > 0) boot--;
           else if (!hold) begin bus.Busy = 1'b0; tst = 1; end
        1: if (hold) bus.Busy = 1'b1;
           else if (bus.Send && !stall) begin
             sh = {1'b1, bus.TxData, 1'b0};
             bus.Busy = 1'b1; line = sh[0]; nb = 0; bc = 0; tst = 2;
           end else bus.Busy = 1'b0;
        2: begin
             bc++;
             if (bc == BIT) begin
               bc = 0; nb++;
               if (nb == 10) tst = 3; else line = sh[nb];
             end
           end
        3: if (!bus.Send) begin bus.Busy = 1'b0; tst = 1; end
        default: tst = 0;
      endcase
    end
  end
  // serial decoder: samples each bit mid-cell
  initial begin : rxm
    forever begin
      @(negedge clk);
      if (line == 1'b0) begin
        repeat (6) @(negedge clk);
        if (line !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          rxb[i] = line;
        end
        repeat (BIT) @(negedge clk);
        if (line !== 1'b1) ferr++;
        rxq.push_back(rxb);
      end
    end
  end
  initial begin : pmon
    send_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Send && !send_prev) pulses++;
      send_prev = bus.Send;
    end
  end
  initial begin
    bus.Write = 1'b0;
    bus.WrData = '0;
    @(negedge clk);
    chk("rst_full", bus.Full, 0);
    chk("rst_empty", bus.Empty, 1);
    chk("rst_txdata", bus.TxData, 0);
    chk("rst_send", bus.Send, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.Send | ~bus.Empty;
    end
    chk("boot_quiet", seen, 0);
`ifdef RS232_TX_FIFO_STATUS_EN
    chk("rst_level", bus.Level, 0);
    chk("rst_ovf", bus.Overflow, 0);
`endif
    hold = 1'b0;
    wait_idle();
    bus.WrData = 8'h55; bus.Write = 1'b1;
    @(negedge clk);
    bus.Write = 1'b0;
    chk("lat_empty", bus.Empty, 0);
    chk("lat_send_n", bus.Send, 0);
    @(negedge clk);
    chk("lat_send_n1", bus.Send, 1);
    chk("lat_txdata", bus.TxData, 8'h55);
    wait_rx(1, 300);
    chk("byte_55", rx_at(0), 8'h55);
    wait_idle();
    chk("drain_empty", bus.Empty, 1);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      bus.WrData = 8'(i); bus.Write = 1'b1;
      @(negedge clk);
    end
    bus.Write = 1'b0;
    chk("fill_full", bus.Full, 1);
    chk("fill_empty", bus.Empty, 0);
    bus.WrData = 8'hAA; bus.Write = 1'b1;
    @(negedge clk);
    bus.Write = 1'b0;
    chk("ovf_full", bus.Full, 1);
`ifdef RS232_TX_FIFO_STATUS_EN
    chk("ovf_level", bus.Level, 16);
    chk("ovf_sticky", bus.Overflow, 1);
`endif
    hold = 1'b0;
    wait_rx(17, 16 * 140 + 200);
    for (int i = 0; i < 16; i++) chk("fill_order", rx_at(1 + i), 32'(i + 1));
    wait_idle();
    chk("fill_drained", bus.Empty, 1);
    chk("fill_notfull", bus.Full, 0);
    chk("fill_pulses", pulses, 17);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.WrData = 8'h21 + 8'(i); bus.Write = 1'b1;
      @(negedge clk);
    end
    bus.Write = 1'b0;
    hold = 1'b0;
`ifdef RS232_TX_FIFO_STATUS_EN
    chk("c3_level", bus.Level, 3);
`endif
    @(negedge clk);
    chk("c3_busy_low", bus.Busy, 0);
    bus.WrData = 8'h24; bus.Write = 1'b1;
    @(negedge clk);
    bus.Write = 1'b0;
    chk("c3_pop_send", bus.Send, 1);
    chk("c3_pop_data", bus.TxData, 8'h21);
    chk("c3_empty", bus.Empty, 0);
`ifdef RS232_TX_FIFO_STATUS_EN
    chk("c3_level_kept", bus.Level, 3);
`endif
    wait_rx(21, 4 * 140 + 200);
    for (int i = 0; i < 4; i++) chk("c3_order", rx_at(17 + i), 32'h21 + 32'(i));
    wait_idle();
    chk("c3_pulses", pulses, 21);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.WrData = 8'h31 + 8'(i); bus.Write = 1'b1;
      @(negedge clk);
    end
    bus.Write = 1'b0;
    @(negedge clk);
    chk("req_send", bus.Send, 1);
    chk("req_data", bus.TxData, 8'h31);
    chk("req_queued", bus.Empty, 0);
    rst = 1'b1;
    #1;
    chk("arst_send", bus.Send, 0);
    chk("arst_empty", bus.Empty, 1);
    chk("arst_full", bus.Full, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    wait_idle();
    bus.WrData = 8'hC3; bus.Write = 1'b1;
    @(negedge clk);
    bus.Write = 1'b0;
    wait_rx(22, 300);
    chk("post_rst_byte", rx_at(21), 8'hC3);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("post_rst_count", rxq.size(), 22);
    chk("post_rst_empty", bus.Empty, 1);
    chk("total_pulses", pulses, 23);
    chk("frame_err", ferr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
